div_unit: RTL and testbench

Multi-cycle 32-bit integer divider and its sequencer, sitting beside the execute stage. It accepts a division request from the execute stage, iterates one quotient bit per cycle, and returns `{remainder, quotient}` for the HI/LO write. The execute stage stalls the pipeline while `start_i && !ready_o`.

---
 rtl/div_unit_pkg.sv | 25 ++
 rtl/div_unit_step.sv | 25 ++
 rtl/div_unit.sv | 135 +++++++++++++
 tb/tb_div_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle divider: FSM states, handshake levels, opcodes.
package div_unit_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_WW    = 2 * DIV_W + 1;
  localparam int unsigned DIV_CNT_W = 6;
  localparam logic [DIV_CNT_W-1:0] DIV_LAST_STEP = DIV_CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  // Execute-stage opcodes that route to this unit.
  localparam logic [7:0] ALU_DIV  = 8'b0001_1010;
  localparam logic [7:0] ALU_DIVU = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration on the 65-bit working register.
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_WW-1:0] i_w,
  input  logic [DIV_W-1:0]  i_divisor,
  output logic [DIV_WW-1:0] o_w_c
);

  logic [DIV_W:0] w_diff;
  logic           w_unused_msb;

  // The partial remainder never exceeds 31 bits before it is compared, so W[64] carries nothing.
  assign w_unused_msb = i_w[DIV_WW-1];
  assign w_diff       = {1'b0, i_w[2*DIV_W-1:DIV_W]} - {1'b0, i_divisor};

  always_comb begin
    if (w_diff[DIV_W]) begin
      o_w_c = {i_w[DIV_WW-2:0], 1'b0};
    end else begin
      o_w_c = {w_diff[DIV_W-1:0], i_w[DIV_W-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// 32-bit multi-cycle divider sequencer returning {remainder, quotient}.
// Define DIV_SIGNED_EN to honor signed_div_i (operand negation and sign fix-up).
module div_unit
  import div_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                annul_i,
  input  logic                signed_div_i,
  input  logic [DIV_W-1:0]    opdata1_i,
  input  logic [DIV_W-1:0]    opdata2_i,
  output logic [2*DIV_W-1:0]  result_o,
  output logic                ready_o
);

  div_state_t             r_state, w_state_nxt;
  logic [DIV_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DIV_WW-1:0]      r_w, w_w_nxt, w_w_step;
  logic [DIV_W-1:0]       r_divisor, w_divisor_nxt;
  logic [2*DIV_W-1:0]     w_result_nxt;
  logic                   w_ready_nxt;
  logic [DIV_W-1:0]       w_op1, w_op2;
  logic [DIV_W-1:0]       w_quot, w_rem;
  logic                   r_neg_q, r_neg_r, w_neg_q_nxt, w_neg_r_nxt;
  logic                   w_neg_q_in, w_neg_r_in;

  div_step u_step (
    .i_w       (r_w),
    .i_divisor (r_divisor),
    .o_w_c     (w_w_step)
  );

`ifdef DIV_SIGNED_EN
  // Iterate on magnitudes; signs are latched at accept for the final fix-up.
  assign w_op1      = (signed_div_i && opdata1_i[DIV_W-1]) ? DIV_W'(~opdata1_i + 1'b1) : opdata1_i;
  assign w_op2      = (signed_div_i && opdata2_i[DIV_W-1]) ? DIV_W'(~opdata2_i + 1'b1) : opdata2_i;
  assign w_neg_q_in = signed_div_i && (opdata1_i[DIV_W-1] ^ opdata2_i[DIV_W-1]);
  assign w_neg_r_in = signed_div_i && opdata1_i[DIV_W-1];
  assign w_quot     = r_neg_q ? DIV_W'(~w_w_step[DIV_W-1:0] + 1'b1) : w_w_step[DIV_W-1:0];
  assign w_rem      = r_neg_r ? DIV_W'(~w_w_step[DIV_WW-1:DIV_W+1] + 1'b1)
                              : w_w_step[DIV_WW-1:DIV_W+1];
`else
  logic w_unused_sign;
  logic w_unused_neg;
  assign w_unused_sign = signed_div_i;
  assign w_unused_neg  = r_neg_q ^ r_neg_r;
  assign w_op1         = opdata1_i;
  assign w_op2         = opdata2_i;
  assign w_neg_q_in    = 1'b0;
  assign w_neg_r_in    = 1'b0;
  assign w_quot        = w_w_step[DIV_W-1:0];
  assign w_rem         = w_w_step[DIV_WW-1:DIV_W+1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= DIV_FREE;
      r_cnt     <= '0;
      r_w       <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      result_o  <= '0;
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_w       <= w_w_nxt;
      r_divisor <= w_divisor_nxt;
      r_neg_q   <= w_neg_q_nxt;
      r_neg_r   <= w_neg_r_nxt;
      result_o  <= w_result_nxt;
      ready_o   <= w_ready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_w_nxt       = r_w;
    w_divisor_nxt = r_divisor;
    w_neg_q_nxt   = r_neg_q;
    w_neg_r_nxt   = r_neg_r;
    w_result_nxt  = result_o;
    w_ready_nxt   = ready_o;
    case (r_state)
      DIV_FREE: begin
        if (!annul_i && start_i == DIV_START) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DIV_BYZERO;
          end else begin
            w_state_nxt   = DIV_ON;
            w_cnt_nxt     = '0;
            w_w_nxt       = {{DIV_W{1'b0}}, w_op1, 1'b0};
            w_divisor_nxt = w_op2;
            w_neg_q_nxt   = w_neg_q_in;
            w_neg_r_nxt   = w_neg_r_in;
          end
        end
      end
      DIV_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_state_nxt  = DIV_END;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_i) begin
          w_state_nxt = DIV_FREE;
        end else begin
          w_w_nxt   = w_w_step;
          w_cnt_nxt = DIV_CNT_W'(r_cnt + 1'b1);
          if (r_cnt == DIV_LAST_STEP) begin
            w_state_nxt  = DIV_END;
            w_result_nxt = {w_rem, w_quot};
            w_ready_nxt  = DIV_RESULT_READY;
          end
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP || annul_i) begin
          w_state_nxt  = DIV_FREE;
          w_result_nxt = '0;
          w_ready_nxt  = DIV_RESULT_NOT_READY;
        end
      end
      default: w_state_nxt = DIV_FREE;
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded random/directed bench for div_unit against an arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [63:0] sb_q[$];
  logic        prev_ready = 1'b0;
  bit          saw_ready;

`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference: divide magnitudes, then quotient sign = XOR of signs, remainder follows dividend.
  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    bit sg;
    if (b == 32'd0) return 64'h0;
    sg = s && SIGNED_EN;
    ua = (sg && a[31]) ? 32'(0 - a) : a;
    ub = (sg && b[31]) ? 32'(0 - b) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sg && (a[31] ^ b[31])) q = 32'(0 - q);
    if (sg && a[31]) r = 32'(0 - r);
    return {r, q};
  endfunction

  // Monitor: every rising ready_o must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ready_o && !prev_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ready", 64'd1, 64'd0);
      end else begin
        check("result", result_o, sb_q.pop_front());
      end
    end
    prev_ready <= ready_o;
  end

  // Issue one division at a negedge; checks latency, hold stability and the drop of ready.
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int hold);
    int cyc;
    int lat_exp;
    lat_exp = (b == 32'd0) ? 2 : 33;
    sb_q.push_back(exp);
    signed_div_i = s;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    cyc          = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
      end
      if (ready_o) break;
    end
    check("latency", 64'(cyc), 64'(lat_exp));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_ready", 64'(ready_o), 64'd1);
      check("hold_result", result_o, exp);
    end
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'd0);
    check("drop_result", result_o, 64'h0);
  endtask

  task automatic watch_idle(input int n);
    saw_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) saw_ready = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] a, b;
    bit          s;
    int          cyc;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,
           SIGNED_EN ? {32'hFFFF_FFFF, 32'hFFFF_FFFD} : {32'd1, 32'h7FFF_FFFC}, 0);
    run_op(1'b1, 32'd5, 32'd0, 64'h0, 0);

    // Annul mid-operation: no result may ever appear.
    signed_div_i = 1'b0; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    watch_idle(40);
    check("annul_no_ready", 64'(saw_ready), 64'd0);
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 0);

    // Reset in the middle of an operation aborts it.
    signed_div_i = 1'b0; opdata1_i = 32'd1234; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_ready", 64'(ready_o), 64'd0);
    check("rst_mid_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    watch_idle(40);
    check("rst_no_ready", 64'(saw_ready), 64'd0);

    // Asynchronous reset while a result is being presented clears it at once.
    sb_q.push_back(model(1'b0, 32'd1000, 32'd9));
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd9; start_i = 1'b1;
    cyc = 0;
    while (cyc < 100 && !ready_o) begin
      @(negedge clk);
      cyc++;
    end
    check("end_reached", 64'(ready_o), 64'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_ready", 64'(ready_o), 64'd0);
    check("async_rst_result", result_o, 64'h0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
           SIGNED_EN ? {32'd0, 32'h8000_0000} : {32'h8000_0000, 32'd0}, 0);
    run_op(1'b0, 32'd77, 32'd10, {32'd7, 32'd7}, 5);

    for (int k = 0; k < 24; k++) begin
      s = 1'($urandom_range(0, 1));
      a = (k % 7 == 3) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom_range(1, 255);
        4:       b = 32'(0 - $urandom_range(1, 255));
        default: b = $urandom;
      endcase
      run_op(s, a, b, model(s, a, b), (k % 5 == 0) ? 2 : 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
